// File: rtl/range_window_monitor_pkg.sv
// Shared helpers for the range window monitor.
// log2: ceil(log2(n)), never less than 1, so a single-window build still
// gets a 1-bit select field.
package range_window_monitor_pkg;

   function automatic int log2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/range_window_monitor_if.sv
// Bus bundle for the range window monitor.
//   cfg_we/cfg_sel/cfg_lo/cfg_hi : window bound write port
//   hold_thresh                  : debounce threshold (quasi-static)
//   in_valid/dat                 : sample stream in
//   out_valid/inr/stable         : per-window results, 2 cycles later
//   below/above                  : window-0 out-of-range side taps
// master drives the inputs of the monitor, slave is the monitor itself.
interface range_window_monitor_if
   import range_window_monitor_pkg::*;
#(
   parameter int WIDTH   = 7,
   parameter int NUM_WIN = 4,
   parameter int HOLD_W  = 4,
   parameter int SEL_W   = log2(NUM_WIN)
) ();
   logic               cfg_we;
   logic [SEL_W-1:0]   cfg_sel;
   logic [WIDTH-1:0]   cfg_lo;
   logic [WIDTH-1:0]   cfg_hi;
   logic [HOLD_W-1:0]  hold_thresh;
   logic               in_valid;
   logic [WIDTH-1:0]   dat;
   logic               out_valid;
   logic [NUM_WIN-1:0] inr;
   logic [NUM_WIN-1:0] stable;
   logic               below;
   logic               above;

   modport master (
      output cfg_we, cfg_sel, cfg_lo, cfg_hi, hold_thresh, in_valid, dat,
      input  out_valid, inr, stable, below, above
   );

   modport slave (
      input  cfg_we, cfg_sel, cfg_lo, cfg_hi, hold_thresh, in_valid, dat,
      output out_valid, inr, stable, below, above
   );
endinterface

// File: rtl/range_window_monitor_window_cmp.sv
// One window of the range monitor: bound registers with their write decode,
// the stage-1 compare, and the stage-2 hit/debounce state.
//   cfg_*       : bound write port, decoded against IDX here
//   hold_thresh : consecutive hits needed for stable (0 acts as 1)
//   dat         : raw sample, compared every cycle
//   v1          : stage-1 valid; gates every stage-2 update
//   ge/lt       : registered stage-1 compare results
//   inr/stable  : registered stage-2 results
module range_window_monitor_window_cmp #(
   parameter int WIDTH      = 7,
   parameter int HOLD_W     = 4,
   parameter int SEL_W      = 2,
   parameter int IDX        = 0,
   parameter int DEFAULT_LO = 85,
   parameter int DEFAULT_HI = 120
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [SEL_W-1:0]  cfg_sel,
   input  logic [WIDTH-1:0]  cfg_lo,
   input  logic [WIDTH-1:0]  cfg_hi,
   input  logic [HOLD_W-1:0] hold_thresh,
   input  logic [WIDTH-1:0]  dat,
   input  logic              v1,
   output logic              ge,
   output logic              lt,
   output logic              inr,
   output logic              stable
);
   localparam int CNT_MAX = (1 << HOLD_W) - 1;

   logic [WIDTH-1:0]  lo_q, lo_d, hi_q, hi_d;
   logic              ge_q, ge_d, lt_q, lt_d;
   logic [HOLD_W-1:0] cnt_q, cnt_d, cnt_nxt, th_eff;
   logic              inr_q, inr_d, stable_q, stable_d;
   logic              wr, hit;

   // Out-of-range selects never match any IDX, so they drop out here.
   assign wr = cfg_we && (cfg_sel == SEL_W'(IDX));

   always_comb begin
      lo_d     = lo_q;
      hi_d     = hi_q;
      cnt_d    = cnt_q;
      inr_d    = inr_q;
      stable_d = stable_q;
      if (wr) begin
         lo_d = cfg_lo;
         hi_d = cfg_hi;
      end
      // Compare against the bounds as they stand before this edge, so a
      // sample arriving with a write still sees the old window.
      ge_d    = (dat >= lo_q);
      lt_d    = (dat <  hi_q);
      hit     = ge_q & lt_q;
      th_eff  = (hold_thresh == '0) ? HOLD_W'(1) : hold_thresh;
      cnt_nxt = !hit ? '0 :
                (cnt_q == HOLD_W'(CNT_MAX)) ? cnt_q : cnt_q + HOLD_W'(1);
      if (v1) begin
         cnt_d    = cnt_nxt;
         inr_d    = hit;
         stable_d = hit && (cnt_nxt >= th_eff);
      end
      // A rewrite restarts the run; stable then only returns via a fresh count.
      if (wr) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_q     <= WIDTH'(DEFAULT_LO);
         hi_q     <= WIDTH'(DEFAULT_HI);
         ge_q     <= 1'b0;
         lt_q     <= 1'b0;
         cnt_q    <= '0;
         inr_q    <= 1'b0;
         stable_q <= 1'b0;
      end else begin
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         ge_q     <= ge_d;
         lt_q     <= lt_d;
         cnt_q    <= cnt_d;
         inr_q    <= inr_d;
         stable_q <= stable_d;
      end
   end

   assign ge     = ge_q;
   assign lt     = lt_q;
   assign inr    = inr_q;
   assign stable = stable_q;
endmodule

// File: rtl/range_window_monitor.sv
// Multi-window range monitor for an unsigned sample stream. Every sample is
// checked against NUM_WIN programmable half-open windows [lo, hi); results
// appear exactly 2 cycles later with per-window hit and debounced stable flags.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of range_window_monitor_if (config, samples, results)
module range_window_monitor
   import range_window_monitor_pkg::*;
#(
   parameter int WIDTH      = 7,
   parameter int NUM_WIN    = 4,
   parameter int HOLD_W     = 4,
   parameter int DEFAULT_LO = 85,
   parameter int DEFAULT_HI = 120
) (
   input  logic              clk,
   input  logic              rst_n,
   range_window_monitor_if.slave bus
);
   localparam int STAGES = 2;

   logic [STAGES:0]    vld_pipe;
   logic [STAGES:1]    vld_pipe_q;
   logic [STAGES:1]    vld_pipe_d;
   logic [NUM_WIN-1:0] ge, lt, inr, stable;
   logic               below_q, below_d, above_q, above_d;
   logic               unused_taps;

   // vld_pipe[0] is the live input; [1] is v1, [STAGES] is out_valid.
   assign vld_pipe = {vld_pipe_q, bus.in_valid};

   for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_win
      range_window_monitor_window_cmp #(
         .WIDTH      (WIDTH),
         .HOLD_W     (HOLD_W),
         .SEL_W      (log2(NUM_WIN)),
         .IDX        (gi),
         .DEFAULT_LO (DEFAULT_LO),
         .DEFAULT_HI (DEFAULT_HI)
      ) u_win (
         .clk         (clk),
         .rst_n       (rst_n),
         .cfg_we      (bus.cfg_we),
         .cfg_sel     (bus.cfg_sel),
         .cfg_lo      (bus.cfg_lo),
         .cfg_hi      (bus.cfg_hi),
         .hold_thresh (bus.hold_thresh),
         .dat         (bus.dat),
         .v1          (vld_pipe[1]),
         .ge          (ge[gi]),
         .lt          (lt[gi]),
         .inr         (inr[gi]),
         .stable      (stable[gi])
      );
   end

   // Only window 0 feeds the side taps; the rest are kept for symmetry.
   assign unused_taps = ^{ge, lt};

   always_comb begin
      vld_pipe_d = vld_pipe[STAGES-1:0];
      below_d    = below_q;
      above_d    = above_q;
      if (vld_pipe[1]) begin
         below_d = ~ge[0];
         above_d = ~lt[0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe_q <= '0;
         below_q    <= 1'b0;
         above_q    <= 1'b0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         below_q    <= below_d;
         above_q    <= above_d;
      end
   end

   assign bus.out_valid = vld_pipe[STAGES];
   assign bus.inr       = inr;
   assign bus.stable    = stable;
   assign bus.below     = below_q;
   assign bus.above     = above_q;
endmodule
